classifier_channel_scheduler: RTL

Time-multiplexes one shared event-classifier core across `NUM_CH` electrode channels. On every sample tick it latches each channel's detection bit, services enabled channels in ascending index order through a req/ack handshake with the core, and collects the per-channel event codes. When the sweep finishes it publishes them as one vector with a single-cycle valid. The block sits between the per-channel spike detectors and the single classifier instance.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/lowest_set_from.sv | 32 +++
 rtl/classifier_channel_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg
//   Event codes and scheduler state encoding shared by the classifier blocks.
//   Revision: 1.0
// ============================================================================
package seg_pkg;

  localparam logic [1:0] EVENT_C = 2'd0;
  localparam logic [1:0] EVENT_B = 2'd1;
  localparam logic [1:0] EVENT_A = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/lowest_set_from.sv
`default_nettype none
// ============================================================================
// lowest_set_from
//   Combinational priority finder: lowest set bit of vec at index >= from.
//   Revision: 1.0
// ============================================================================
module lowest_set_from #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W:0]   from,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam int FROM_W = IDX_W + 1;

  // Scan downward so the last match written is the lowest qualifying index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i] && (FROM_W'(i) >= from)) begin
        idx   = i[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/classifier_channel_scheduler.sv
`default_nettype none
// ============================================================================
// classifier_channel_scheduler
//   Sweeps enabled channels through one shared classifier core per sample tick.
//   Revision: 1.0
// ============================================================================
module classifier_channel_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [NUM_CH-1:0]     det_in,
  input  logic [NUM_CH-1:0]     ch_en,
  output logic                  core_req,
  output logic [CH_W-1:0]       core_ch,
  output logic                  core_det,
  input  logic                  core_ack,
  input  logic [1:0]            core_event,
  output logic [2*NUM_CH-1:0]   event_vec,
  output logic                  event_valid,
  output logic                  busy,
  output logic [NUM_CH-1:0]     fault_vec,
  output logic [7:0]            overrun_cnt
);

  import seg_pkg::*;

  localparam logic [7:0]    c_timeout_last = 8'(ACK_TIMEOUT - 1);
  localparam logic [CH_W:0] c_ptr_step     = {{CH_W{1'b0}}, 1'b1};

  sched_state_t        r_state;
  logic [NUM_CH-1:0]   r_det_q;
  logic [NUM_CH-1:0]   r_en_q;
  logic [CH_W:0]       r_ptr;
  logic [7:0]          r_wait_cnt;
  logic [2*NUM_CH-1:0] r_slots;
  logic [CH_W-1:0]     w_next_ch;
  logic                w_found;
  logic [1:0]          w_code;

  // The pointer is one bit wider than a channel index so it can step past the last channel.
  lowest_set_from #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_finder (
    .vec   (r_en_q),
    .from  (r_ptr),
    .idx   (w_next_ch),
    .found (w_found)
  );

  assign w_code = (core_event == 2'd3) ? EVENT_C : core_event;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_det_q     <= '0;
      r_en_q      <= '0;
      r_ptr       <= '0;
      r_wait_cnt  <= '0;
      r_slots     <= '0;
      core_req    <= 1'b0;
      core_ch     <= '0;
      core_det    <= 1'b0;
      event_vec   <= '0;
      event_valid <= 1'b0;
      busy        <= 1'b0;
      fault_vec   <= '0;
      overrun_cnt <= '0;
    end else begin
      event_valid <= 1'b0;
      if (sample_tick && (r_state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (sample_tick) begin
            r_det_q <= det_in;
            r_en_q  <= ch_en;
            r_slots <= '0;
            r_ptr   <= '0;
            busy    <= 1'b1;
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (w_found) begin
            core_ch    <= w_next_ch;
            core_det   <= r_det_q[w_next_ch];
            core_req   <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= ST_ISSUE;
          end else begin
            r_state <= ST_DONE;
          end
        end

        ST_ISSUE: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (core_ack || (r_wait_cnt == c_timeout_last)) begin
            r_slots[{core_ch, 1'b0} +: 2] <= core_ack ? w_code : EVENT_C;
            if (!core_ack) begin
              fault_vec[core_ch] <= 1'b1;
            end
            r_ptr    <= {1'b0, core_ch} + c_ptr_step;
            core_req <= 1'b0;
            r_state  <= ST_SCAN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          event_vec   <= r_slots;
          event_valid <= 1'b1;
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
